// File: rtl/serdes_pkg.sv
// serdes_pkg -- constants and types shared by the LVDS link serializers and
// deserializers.
//
// Build option:
//   SERDES_PARITY_EN -- when defined, each lane appends an even-parity bit
//                       after its payload. The bit counter then ends at 33
//                       instead of 32. Both ends of the link must agree on
//                       this setting.
//
// No ports (package).
package serdes_pkg;

  localparam int   CTRL_W    = 5;
  localparam int   DATA_W    = 32;
  localparam int   FRAME_W   = CTRL_W + DATA_W;  // 37
  localparam logic START_BIT = 1'b1;

`ifdef SERDES_PARITY_EN
  localparam bit         PARITY_EN = 1'b1;
  localparam logic [5:0] BIT_TERM  = 6'd33;  // last counter value in SEND
`else
  localparam bit         PARITY_EN = 1'b0;
  localparam logic [5:0] BIT_TERM  = 6'd32;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/mas_frame_serializer_if.sv
// mas_frame_serializer_if -- word handshake and serial-lane bundle of the
// master transmit stage.
//
// Signals:
//   data_i   [36:0] word to send ([4:0] lane 0, [36:5] lane 1)
//   valid_i         data_i is valid
//   ready_o         serializer idle, accepts a word this edge
//   serial_o [1:0]  lane outputs ([0] control field, [1] data field)
//   busy_o          frame in flight (SEND or GAP)
//
// Modports:
//   master -- the word producer (drives data_i/valid_i)
//   slave  -- the serializer
interface mas_frame_serializer_if;

  logic [serdes_pkg::FRAME_W-1:0] data_i;
  logic                           valid_i;
  logic                           ready_o;
  logic [1:0]                     serial_o;
  logic                           busy_o;

  modport master (
    output data_i,
    output valid_i,
    input  ready_o,
    input  serial_o,
    input  busy_o
  );

  modport slave (
    input  data_i,
    input  valid_i,
    output ready_o,
    output serial_o,
    output busy_o
  );

endinterface

// File: rtl/mas_frame_serializer_lane.sv
// serializer_lane -- one serial lane of the frame serializer.
//
// Emits a frame of: start bit, W payload bits LSB-first, then (when
// SERDES_PARITY_EN is defined) one even-parity bit, then holds low until
// cleared. The top level sequences all lanes in lock-step with load/shift/
// clear strobes, so a narrow lane simply idles low while a wider one is
// still sending.
//
// Ports:
//   clk      in  clock
//   reset    in  asynchronous active-high reset
//   load     in  capture payload, drive the start bit
//   payload  in  W-bit field to send
//   shift    in  advance to the next bit of the frame
//   clear    in  end of frame, force the line low
//   serial   out registered lane output
module serializer_lane
  import serdes_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] payload,
  input  logic         shift,
  input  logic         clear,
  output logic         serial
);

  localparam int            CW  = $clog2(W + 1);
  localparam logic [CW-1:0] LEN = CW'(W);

  logic [W-1:0]  shift_reg;
  logic [CW-1:0] left_reg;      // payload bits still to be sent
  logic          par_reg;       // running XOR of bits already sent
  logic          par_pend_reg;  // parity bit still owed for this frame
  logic          serial_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg    <= '0;
      left_reg     <= '0;
      par_reg      <= 1'b0;
      par_pend_reg <= 1'b0;
      serial_reg   <= 1'b0;
    end else if (load) begin
      shift_reg    <= payload;
      left_reg     <= LEN;
      par_reg      <= 1'b0;
      par_pend_reg <= PARITY_EN;
      serial_reg   <= START_BIT;
    end else if (clear) begin
      left_reg     <= '0;
      par_pend_reg <= 1'b0;
      serial_reg   <= 1'b0;
    end else if (shift) begin
      if (left_reg != '0) begin
        serial_reg <= shift_reg[0];
        par_reg    <= par_reg ^ shift_reg[0];
        shift_reg  <= shift_reg >> 1;
        left_reg   <= left_reg - CW'(1);
      end else if (par_pend_reg) begin
        // XOR of the payload is exactly the even-parity bit.
        serial_reg   <= par_reg;
        par_pend_reg <= 1'b0;
      end else begin
        serial_reg <= 1'b0;
      end
    end
  end

  assign serial = serial_reg;

endmodule

// File: rtl/mas_frame_serializer.sv
// mas_frame_serializer -- master transmit stage of the two-lane LVDS link.
//
// Accepts one 37-bit word per valid/ready handshake and sends it as two
// lock-step serial frames: lane 0 carries word[4:0], lane 1 carries
// word[36:5]. Each frame is a start bit, payload LSB-first, optional parity
// (SERDES_PARITY_EN), followed by a one-cycle GAP so every lane shows at
// least two low cycles before the next start bit.
//
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous active-high reset (aborts a frame in flight)
//   bus    slave modport of mas_frame_serializer_if
//            data_i/valid_i in, ready_o/serial_o/busy_o out (all registered)
module mas_frame_serializer
  import serdes_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  mas_frame_serializer_if.slave bus
);

  state_t     state_reg;
  logic [5:0] cnt_reg;    // bit index k within the frame, 0 = start bit
  logic       ready_reg;
  logic       busy_reg;

  logic       accept;
  logic       lane_shift;
  logic       lane_clear;
  logic [1:0] lane_serial;

  // Lane strobes decode the registered state; the lanes register their own
  // outputs, so serial_o stays a flop output.
  always_comb begin
    accept     = (state_reg == IDLE) && bus.valid_i && ready_reg;
    lane_shift = (state_reg == SEND) && (cnt_reg != BIT_TERM);
    lane_clear = (state_reg == SEND) && (cnt_reg == BIT_TERM);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ready_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg <= SEND;
            cnt_reg   <= '0;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b1;
          end else begin
            ready_reg <= 1'b1;
          end
        end
        SEND: begin
          if (cnt_reg == BIT_TERM) begin
            state_reg <= GAP;
          end else begin
            cnt_reg <= cnt_reg + 6'd1;
          end
        end
        GAP: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  serializer_lane #(.W(CTRL_W)) u_lane_ctrl (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .payload (bus.data_i[CTRL_W-1:0]),
    .shift   (lane_shift),
    .clear   (lane_clear),
    .serial  (lane_serial[0])
  );

  serializer_lane #(.W(DATA_W)) u_lane_data (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .payload (bus.data_i[FRAME_W-1:CTRL_W]),
    .shift   (lane_shift),
    .clear   (lane_clear),
    .serial  (lane_serial[1])
  );

  assign bus.serial_o = lane_serial;
  assign bus.ready_o  = ready_reg;
  assign bus.busy_o   = busy_reg;

endmodule
